// File: rtl/tl_arb_pkg.sv
// Shared types and constants for the two-to-one TileLink arbiter.
package tl_arb_pkg;

  // Field widths of the TileLink port shared by all three buses.
  localparam int unsigned TL_AW = 32;
  localparam int unsigned TL_DW = 32;
  localparam int unsigned TL_SW = 4;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2,
    ARB_HOLD = 2'd3
  } arb_state_e;

  // Current bus owner, also the debug encoding on owner_o.
  typedef logic [1:0] owner_t;
  localparam owner_t OWN_NONE = 2'd0;
  localparam owner_t OWN_IF   = 2'd1;
  localparam owner_t OWN_MA   = 2'd2;

  // Consecutive-MA-grant counter.
  localparam int unsigned STREAK_W = 4;
  typedef logic [STREAK_W-1:0] streak_t;

  // Saturating increment of the MA streak counter.
  function automatic streak_t streak_inc(input streak_t cur, input streak_t max);
    if (cur >= max) begin
      return max;
    end
    return streak_t'(cur + 1'b1);
  endfunction

endpackage

// File: rtl/tl_arbiter_if.sv
// Single-beat TileLink A/D channel bundle.
//
// Handshake: a beat transfers on a rising clock edge where valid and ready are
// both high. A sender holds valid and its payload stable until that edge; ready
// may depend combinationally on valid. The master drives A and d_ready, the
// slave drives a_ready and D.
interface tilelink #(
  parameter int unsigned AW = tl_arb_pkg::TL_AW,
  parameter int unsigned DW = tl_arb_pkg::TL_DW,
  parameter int unsigned SW = tl_arb_pkg::TL_SW
) ();

  logic            a_valid;
  logic            a_ready;
  logic [2:0]      a_opcode;
  logic [2:0]      a_param;
  logic [2:0]      a_size;
  logic [SW-1:0]   a_source;
  logic [AW-1:0]   a_address;
  logic [DW/8-1:0] a_mask;
  logic [DW-1:0]   a_data;

  logic            d_valid;
  logic            d_ready;
  logic [2:0]      d_opcode;
  logic [2:0]      d_size;
  logic [SW-1:0]   d_source;
  logic [DW-1:0]   d_data;
  logic            d_error;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    input  a_ready,
    input  d_valid, d_opcode, d_size, d_source, d_data, d_error,
    output d_ready
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    output a_ready,
    output d_valid, d_opcode, d_size, d_source, d_data, d_error,
    input  d_ready
  );

endinterface

// File: rtl/tl_arb_pick.sv
// Combinational grant selector: MA has priority, but once MA has won
// MAX_MA_STREAK times in a row while IF waited, IF is let in.
module tl_arb_pick
  import tl_arb_pkg::*;
#(
  parameter int unsigned MAX_MA_STREAK = 4
) (
  input  logic    if_pend_i,
  input  logic    ma_pend_i,
  input  streak_t ma_streak_i,
  output owner_t  grant_o
);

  localparam streak_t STREAK_MAX = streak_t'(MAX_MA_STREAK);

  logic if_forced;

  assign if_forced = if_pend_i && (ma_streak_i == STREAK_MAX);

  // Priority pick with the starvation override for IF.
  always_comb begin
    grant_o = OWN_NONE;
    if (ma_pend_i && !if_forced) begin
      grant_o = OWN_MA;
    end else if (if_pend_i) begin
      grant_o = OWN_IF;
    end
  end

endmodule

// File: rtl/tl_arbiter.sv
// Two-to-one TileLink arbiter: IF and MA MMU buses share one memory port,
// one single-beat transaction outstanding, with lock hints that keep an
// owner on the bus (HOLD) across dependent transactions.
// MAX_MA_STREAK legal range is 1..15.
module tl_arbiter
  import tl_arb_pkg::*;
#(
  parameter int unsigned MAX_MA_STREAK = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       if_request_i,
  input  logic       ma_request_i,
  tilelink.slave     if_bus,
  tilelink.slave     ma_bus,
  tilelink.master    mem_bus,
  output owner_t     owner_o,
  output arb_state_e state_o
);

  localparam streak_t STREAK_MAX = streak_t'(MAX_MA_STREAK);

  arb_state_e state_q, state_d;
  owner_t     owner_q, owner_d;
  streak_t    streak_q, streak_d;

  logic   if_pend;
  logic   ma_pend;
  owner_t pick_grant;

  // Owner-side view, selected by owner_q.
  logic                own_a_valid;
  logic [2:0]          own_a_opcode;
  logic [2:0]          own_a_param;
  logic [2:0]          own_a_size;
  logic [TL_SW-1:0]    own_a_source;
  logic [TL_AW-1:0]    own_a_address;
  logic [TL_DW/8-1:0]  own_a_mask;
  logic [TL_DW-1:0]    own_a_data;
  logic                own_d_ready;
  logic                own_request;

  logic fwd_a;
  logic fwd_d;
  logic a_fire;
  logic d_fire;

  assign if_pend = if_request_i | if_bus.a_valid;
  assign ma_pend = ma_request_i | ma_bus.a_valid;

  tl_arb_pick #(
    .MAX_MA_STREAK(MAX_MA_STREAK)
  ) u_pick (
    .if_pend_i  (if_pend),
    .ma_pend_i  (ma_pend),
    .ma_streak_i(streak_q),
    .grant_o    (pick_grant)
  );

  // Select the current owner's A channel, d_ready and lock hint.
  always_comb begin
    own_a_valid   = 1'b0;
    own_a_opcode  = '0;
    own_a_param   = '0;
    own_a_size    = '0;
    own_a_source  = '0;
    own_a_address = '0;
    own_a_mask    = '0;
    own_a_data    = '0;
    own_d_ready   = 1'b0;
    own_request   = 1'b0;
    if (owner_q == OWN_IF) begin
      own_a_valid   = if_bus.a_valid;
      own_a_opcode  = if_bus.a_opcode;
      own_a_param   = if_bus.a_param;
      own_a_size    = if_bus.a_size;
      own_a_source  = if_bus.a_source;
      own_a_address = if_bus.a_address;
      own_a_mask    = if_bus.a_mask;
      own_a_data    = if_bus.a_data;
      own_d_ready   = if_bus.d_ready;
      own_request   = if_request_i;
    end else if (owner_q == OWN_MA) begin
      own_a_valid   = ma_bus.a_valid;
      own_a_opcode  = ma_bus.a_opcode;
      own_a_param   = ma_bus.a_param;
      own_a_size    = ma_bus.a_size;
      own_a_source  = ma_bus.a_source;
      own_a_address = ma_bus.a_address;
      own_a_mask    = ma_bus.a_mask;
      own_a_data    = ma_bus.a_data;
      own_d_ready   = ma_bus.d_ready;
      own_request   = ma_request_i;
    end
  end

  // A forwards in ADDR and HOLD so a locked owner's next beat needs no bubble.
  assign fwd_a  = (state_q == ARB_ADDR) || (state_q == ARB_HOLD);
  assign fwd_d  = (state_q == ARB_DATA);
  assign a_fire = fwd_a && own_a_valid && mem_bus.a_ready;
  assign d_fire = fwd_d && mem_bus.d_valid && own_d_ready;

  // State, owner and streak registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      owner_q  <= OWN_NONE;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
    end
  end

  // Next-state logic: arbitrate in IDLE, follow the A/D handshakes otherwise.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    streak_d = streak_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_grant != OWN_NONE) begin
          state_d = ARB_ADDR;
          owner_d = pick_grant;
          if ((pick_grant == OWN_MA) && if_pend) begin
            streak_d = streak_inc(streak_q, STREAK_MAX);
          end else begin
            streak_d = '0;
          end
        end
      end
      ARB_ADDR: begin
        if (a_fire) begin
          state_d = ARB_DATA;
        end
      end
      ARB_DATA: begin
        if (d_fire) begin
          if (own_request) begin
            state_d = ARB_HOLD;
          end else begin
            state_d = ARB_IDLE;
            owner_d = OWN_NONE;
          end
        end
      end
      ARB_HOLD: begin
        if (own_a_valid) begin
          state_d = a_fire ? ARB_DATA : ARB_ADDR;
        end else if (!own_request) begin
          state_d = ARB_IDLE;
          owner_d = OWN_NONE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  // Memory-side outputs: owner's A when forwarding, owner's d_ready in DATA.
  always_comb begin
    mem_bus.a_valid   = fwd_a && own_a_valid;
    mem_bus.a_opcode  = own_a_opcode;
    mem_bus.a_param   = own_a_param;
    mem_bus.a_size    = own_a_size;
    mem_bus.a_source  = own_a_source;
    mem_bus.a_address = own_a_address;
    mem_bus.a_mask    = own_a_mask;
    mem_bus.a_data    = own_a_data;
    mem_bus.d_ready   = fwd_d && own_d_ready;
  end

  // Requester-side outputs: only the owner ever sees a_ready or d_valid.
  always_comb begin
    if_bus.a_ready  = fwd_a && (owner_q == OWN_IF) && mem_bus.a_ready;
    if_bus.d_valid  = fwd_d && (owner_q == OWN_IF) && mem_bus.d_valid;
    if_bus.d_opcode = mem_bus.d_opcode;
    if_bus.d_size   = mem_bus.d_size;
    if_bus.d_source = mem_bus.d_source;
    if_bus.d_data   = mem_bus.d_data;
    if_bus.d_error  = mem_bus.d_error;
    ma_bus.a_ready  = fwd_a && (owner_q == OWN_MA) && mem_bus.a_ready;
    ma_bus.d_valid  = fwd_d && (owner_q == OWN_MA) && mem_bus.d_valid;
    ma_bus.d_opcode = mem_bus.d_opcode;
    ma_bus.d_size   = mem_bus.d_size;
    ma_bus.d_source = mem_bus.d_source;
    ma_bus.d_data   = mem_bus.d_data;
    ma_bus.d_error  = mem_bus.d_error;
  end

  assign owner_o = owner_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_tl_arbiter.sv
// Directed bench for tl_arbiter: grant order and routed read data are
// checked against expected queues filled as each request is issued.
module tb_tl_arbiter;
  import tl_arb_pkg::*;

  localparam int W = 34;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic if_request = 1'b0;
  logic ma_request = 1'b0;
  owner_t owner;
  arb_state_e state;

  tilelink if_bus ();
  tilelink ma_bus ();
  tilelink mem_bus ();

  tl_arbiter #(
    .MAX_MA_STREAK(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_request_i(if_request),
    .ma_request_i(ma_request),
    .if_bus      (if_bus),
    .ma_bus      (ma_bus),
    .mem_bus     (mem_bus),
    .owner_o     (owner),
    .state_o     (state)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int vectors = 0;
  int miscompares = 0;
  int d_done = 0;
  logic [W-1:0] exp_q[$];   // {owner, address} in expected A-grant order
  logic [W-1:0] dexp_q[$];  // {owner, data} in expected D-completion order
  logic [31:0] if_q[$];
  logic [31:0] ma_q[$];
  logic mem_auto = 1'b0;

  function automatic logic [31:0] resp_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_d(input int target, input string tag);
    int g = 0;
    while (d_done < target && g < 300) begin
      @(posedge clk); #1;
      g++;
    end
    chk(tag, 64'(d_done), 64'(target));
  endtask

  // ---------------- driver: IF master ----------------
  initial begin : if_master
    logic fire;
    if_bus.a_valid = 1'b0; if_bus.a_opcode = 3'd4; if_bus.a_param = 3'd0;
    if_bus.a_size = 3'd2; if_bus.a_source = 4'd1; if_bus.a_address = '0;
    if_bus.a_mask = 4'hF; if_bus.a_data = '0;
    forever begin
      @(negedge clk);
      fire = if_bus.a_valid && if_bus.a_ready;
      @(posedge clk); #1;
      if (fire) begin
        void'(if_q.pop_front());
        if_bus.a_valid = 1'b0;
      end
      if (!if_bus.a_valid && if_q.size() != 0) begin
        if_bus.a_valid = 1'b1;
        if_bus.a_address = if_q[0];
      end
    end
  end

  // ---------------- driver: MA master ----------------
  initial begin : ma_master
    logic fire;
    ma_bus.a_valid = 1'b0; ma_bus.a_opcode = 3'd4; ma_bus.a_param = 3'd0;
    ma_bus.a_size = 3'd2; ma_bus.a_source = 4'd2; ma_bus.a_address = '0;
    ma_bus.a_mask = 4'hF; ma_bus.a_data = '0;
    forever begin
      @(negedge clk);
      fire = ma_bus.a_valid && ma_bus.a_ready;
      @(posedge clk); #1;
      if (fire) begin
        void'(ma_q.pop_front());
        ma_bus.a_valid = 1'b0;
      end
      if (!ma_bus.a_valid && ma_q.size() != 0) begin
        ma_bus.a_valid = 1'b1;
        ma_bus.a_address = ma_q[0];
      end
    end
  end

  // ---------------- driver: memory responder (auto mode) ----------------
  initial begin : mem_model
    logic a_fire, d_fire;
    logic [31:0] a_addr;
    a_addr = '0;
    mem_bus.a_ready = 1'b0; mem_bus.d_valid = 1'b0; mem_bus.d_opcode = 3'd1;
    mem_bus.d_size = 3'd2; mem_bus.d_source = '0; mem_bus.d_data = '0;
    mem_bus.d_error = 1'b0;
    forever begin
      @(negedge clk);
      a_fire = mem_bus.a_valid && mem_bus.a_ready;
      d_fire = mem_bus.d_valid && mem_bus.d_ready;
      if (a_fire) a_addr = mem_bus.a_address;
      @(posedge clk); #1;
      if (mem_auto) begin
        if (d_fire) mem_bus.d_valid = 1'b0;
        if (a_fire) begin
          mem_bus.d_valid = 1'b1;
          mem_bus.d_data = resp_of(a_addr);
        end
        mem_bus.a_ready = !mem_bus.d_valid;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mem_bus.a_valid && mem_bus.a_ready) begin
          if (exp_q.size() == 0) begin
            chk("a_unexpected_grant", 64'(exp_q.size()), 64'd1);
          end else begin
            e = exp_q.pop_front();
            chk("a_grant", {30'd0, owner, mem_bus.a_address}, 64'(e));
          end
        end
        if (if_bus.d_valid && if_bus.d_ready) begin
          d_done++;
          if (dexp_q.size() == 0) chk("d_if_unexpected", 64'(dexp_q.size()), 64'd1);
          else begin
            e = dexp_q.pop_front();
            chk("d_if_route", {30'd0, OWN_IF, if_bus.d_data}, 64'(e));
          end
        end
        if (ma_bus.d_valid && ma_bus.d_ready) begin
          d_done++;
          if (dexp_q.size() == 0) chk("d_ma_unexpected", 64'(dexp_q.size()), 64'd1);
          else begin
            e = dexp_q.pop_front();
            chk("d_ma_route", {30'd0, OWN_MA, ma_bus.d_data}, 64'(e));
          end
        end
        if (mem_bus.d_valid && owner == OWN_NONE) begin
          chk("d_ready_outside_data", 64'(mem_bus.d_ready), 64'd0);
        end
      end
    end
  end

  // ---------------- global time bound ----------------
  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin : main
    int guard;
    int base;
    if_bus.d_ready = 1'b1;
    ma_bus.d_ready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_owner", 64'(owner), 64'(OWN_NONE));
    chk("rst_state", 64'(state), 64'(ARB_IDLE));
    chk("rst_mem_a_valid", 64'(mem_bus.a_valid), 64'd0);
    chk("rst_mem_d_ready", 64'(mem_bus.d_ready), 64'd0);
    chk("rst_ready_valid", {60'd0, if_bus.a_ready, ma_bus.a_ready, if_bus.d_valid, ma_bus.d_valid}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);

    // IF-only read, cycle-exact with a hand-driven memory
    exp_q.push_back({OWN_IF, 32'h8000_0000});
    dexp_q.push_back({OWN_IF, 32'h0000_1234});
    if_q.push_back(32'h8000_0000);
    guard = 0;
    do begin @(negedge clk); guard++; end while (!if_bus.a_valid && guard < 20);
    chk("if_c0_if_a_valid", 64'(if_bus.a_valid), 64'd1);
    chk("if_c0_owner", 64'(owner), 64'(OWN_NONE));
    chk("if_c0_mem_a_valid", 64'(mem_bus.a_valid), 64'd0);
    @(posedge clk); #1; mem_bus.a_ready = 1'b1;
    @(negedge clk);
    chk("if_c1_mem_a_valid", 64'(mem_bus.a_valid), 64'd1);
    chk("if_c1_mem_addr", 64'(mem_bus.a_address), 64'h8000_0000);
    chk("if_c1_owner", 64'(owner), 64'(OWN_IF));
    chk("if_c1_if_a_ready", 64'(if_bus.a_ready), 64'd1);
    chk("if_c1_ma_a_ready", 64'(ma_bus.a_ready), 64'd0);
    @(posedge clk); #1; mem_bus.a_ready = 1'b0;
    @(negedge clk);
    chk("if_c2_state", 64'(state), 64'(ARB_DATA));
    chk("if_c2_mem_a_valid", 64'(mem_bus.a_valid), 64'd0);
    @(posedge clk); #1; mem_bus.d_valid = 1'b1; mem_bus.d_data = 32'h0000_1234;
    @(negedge clk);
    chk("if_c3_if_d_valid", 64'(if_bus.d_valid), 64'd1);
    chk("if_c3_if_d_data", 64'(if_bus.d_data), 64'h1234);
    chk("if_c3_mem_d_ready", 64'(mem_bus.d_ready), 64'd1);
    chk("if_c3_ma_d_valid", 64'(ma_bus.d_valid), 64'd0);
    @(posedge clk); #1; mem_bus.d_valid = 1'b0;
    @(negedge clk);
    chk("if_c4_owner", 64'(owner), 64'(OWN_NONE));
    chk("if_c4_state", 64'(state), 64'(ARB_IDLE));

    // Tie: MA first, then IF after one bubble
    mem_auto = 1'b1;
    mem_bus.a_ready = 1'b1;
    base = d_done;
    exp_q.push_back({OWN_MA, 32'h1000_0010});
    exp_q.push_back({OWN_IF, 32'h2000_0020});
    dexp_q.push_back({OWN_MA, resp_of(32'h1000_0010)});
    dexp_q.push_back({OWN_IF, resp_of(32'h2000_0020)});
    ma_q.push_back(32'h1000_0010);
    if_q.push_back(32'h2000_0020);
    wait_d(base + 1, "tie_ma_done");
    @(negedge clk);
    chk("tie_bubble_owner", 64'(owner), 64'(OWN_NONE));
    @(posedge clk); #1;
    @(negedge clk);
    chk("tie_if_owner", 64'(owner), 64'(OWN_IF));
    wait_d(base + 2, "tie_if_done");
    repeat (2) @(negedge clk);

    // Starvation guard: MA x4, IF, MA x2
    base = d_done;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) begin
        exp_q.push_back({OWN_IF, 32'h4000_0000});
        dexp_q.push_back({OWN_IF, resp_of(32'h4000_0000)});
      end
      exp_q.push_back({OWN_MA, 32'h3000_0000 + 32'(i * 4)});
      dexp_q.push_back({OWN_MA, resp_of(32'h3000_0000 + 32'(i * 4))});
      ma_q.push_back(32'h3000_0000 + 32'(i * 4));
    end
    if_q.push_back(32'h4000_0000);
    wait_d(base + 7, "starve_done");
    repeat (2) @(negedge clk);

    // Lock: MA keeps the bus for two transactions while IF waits
    base = d_done;
    ma_request = 1'b1;
    exp_q.push_back({OWN_MA, 32'h5000_0000});
    exp_q.push_back({OWN_MA, 32'h5000_0004});
    exp_q.push_back({OWN_IF, 32'h6000_0000});
    dexp_q.push_back({OWN_MA, resp_of(32'h5000_0000)});
    dexp_q.push_back({OWN_MA, resp_of(32'h5000_0004)});
    dexp_q.push_back({OWN_IF, resp_of(32'h6000_0000)});
    ma_q.push_back(32'h5000_0000);
    ma_q.push_back(32'h5000_0004);
    if_q.push_back(32'h6000_0000);
    wait_d(base + 2, "lock_ma_done");
    @(negedge clk);
    @(negedge clk);
    chk("lock_hold_state", 64'(state), 64'(ARB_HOLD));
    chk("lock_hold_owner", 64'(owner), 64'(OWN_MA));
    chk("lock_if_a_ready", 64'(if_bus.a_ready), 64'd0);
    ma_request = 1'b0;
    wait_d(base + 3, "lock_if_done");
    repeat (2) @(negedge clk);

    // Backpressure on A and D
    mem_auto = 1'b0;
    mem_bus.a_ready = 1'b0;
    exp_q.push_back({OWN_MA, 32'h7000_0000});
    dexp_q.push_back({OWN_MA, 32'hBEEF_0001});
    ma_q.push_back(32'h7000_0000);
    guard = 0;
    do begin @(negedge clk); guard++; end while (!mem_bus.a_valid && guard < 20);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_a_held_%0d", i),
          {31'd0, mem_bus.a_valid, ma_bus.a_ready, mem_bus.a_address},
          {31'd0, 1'b1, 1'b0, 32'h7000_0000});
      @(negedge clk);
    end
    @(posedge clk); #1; mem_bus.a_ready = 1'b1;
    @(negedge clk);
    chk("bp_a_release", 64'(ma_bus.a_ready), 64'd1);
    @(posedge clk); #1;
    mem_bus.a_ready = 1'b0; ma_bus.d_ready = 1'b0;
    mem_bus.d_valid = 1'b1; mem_bus.d_data = 32'hBEEF_0001; mem_bus.d_source = 4'h9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp_d_stall_%0d", i),
          {58'd0, mem_bus.d_ready, ma_bus.d_valid, state, owner},
          {58'd0, 1'b0, 1'b1, ARB_DATA, OWN_MA});
      @(posedge clk); #1;
    end
    ma_bus.d_ready = 1'b1;
    @(negedge clk);
    chk("bp_d_ready_mirror", 64'(mem_bus.d_ready), 64'd1);
    chk("bp_d_source", 64'(ma_bus.d_source), 64'h9);
    @(posedge clk); #1; mem_bus.d_valid = 1'b0;
    @(negedge clk);
    chk("bp_idle", 64'(state), 64'(ARB_IDLE));

    // Reset in the middle of DATA
    exp_q.push_back({OWN_IF, 32'h9000_0000});
    if_request = 1'b1;
    if_bus.d_ready = 1'b0;
    if_q.push_back(32'h9000_0000);
    guard = 0;
    do begin @(negedge clk); guard++; end while (!mem_bus.a_valid && guard < 20);
    @(posedge clk); #1; mem_bus.a_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    mem_bus.a_ready = 1'b0; mem_bus.d_valid = 1'b1; mem_bus.d_data = 32'hDEAD_0000;
    @(negedge clk);
    chk("rstm_pre_state", 64'(state), 64'(ARB_DATA));
    chk("rstm_pre_if_d_valid", 64'(if_bus.d_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstm_state", 64'(state), 64'(ARB_IDLE));
    chk("rstm_owner", 64'(owner), 64'(OWN_NONE));
    chk("rstm_mem", {62'd0, mem_bus.a_valid, mem_bus.d_ready}, 64'd0);
    chk("rstm_req", {60'd0, if_bus.a_ready, ma_bus.a_ready, if_bus.d_valid, ma_bus.d_valid}, 64'd0);
    @(posedge clk); #1;
    mem_bus.d_valid = 1'b0; if_request = 1'b0; if_bus.d_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rstm_after_owner", 64'(owner), 64'(OWN_NONE));
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("dexp_q_drained", 64'(dexp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tl_arbiter.md
# tl_arbiter

Two-to-one TileLink arbiter sharing the single physical memory port between the instruction-fetch MMU bus (`if_phy_bus`) and the memory-access MMU bus (`ma_phy_bus`). It sits between the two CPU-side masters and the SoC memory/bus fabric, and allows one outstanding single-beat transaction at a time. It honours the `if_request` / `ma_request` lock hints so that a page-table walk plus its data access stays atomic. Memory-access has priority, with a starvation guard for fetch.

## Interface
- `MAX_MA_STREAK`, 4: consecutive MA grants allowed while IF is pending before IF is forced in; legal range 1..15.
- `clk`  in  1  system clock; one clock domain.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `if_request`  in  1  IF lock/pending hint from the fetch stage.
- `ma_request`  in  1  MA lock/pending hint from the access stage.
- `if_bus`  `tilelink.slave`  —  IF side; driven by the IF MMU's physical bus.
- `ma_bus`  `tilelink.slave`  —  MA side; driven by the MA MMU's physical bus.
- `mem_bus`  `tilelink.master`  —  shared port to the memory fabric.
- `owner`  out  2  debug: 0 none, 1 IF, 2 MA.

## Operation
- Pending: IF pending = `if_request | if_bus.a_valid`; MA pending is the same with the MA signals.
- FSM states: IDLE, ADDR, DATA, HOLD.
- IDLE:
  - Arbitration picks an owner if any requester is pending, registers it, and goes to ADDR.
  - Selection: MA wins a tie unless `ma_streak == MAX_MA_STREAK`, in which case IF wins.
- ADDR:
  - All A signals of the owner are muxed to `mem_bus`.
  - `owner.a_ready = mem_bus.a_ready`.
  - On the A handshake, go to DATA.
- DATA:
  - `mem_bus.d_*` (data, opcode, size, source, error) is routed to the owner.
  - `mem_bus.d_ready = owner.d_ready`.
  - On the D handshake: go to HOLD if the owner's request is high, else IDLE.
- HOLD:
  - Owner keeps the bus; there is no re-arbitration.
  - Owner `a_valid` → ADDR (same forwarding rules).
  - Owner request falling with no `a_valid` → IDLE.
- Non-owner sees `a_ready = 0` and `d_valid = 0` at all times.
- `ma_streak` (4 bit):
  - Increments on each MA grant made in IDLE while IF is pending, saturating at `MAX_MA_STREAK`.
  - Clears on any IF grant, or on an MA grant made while IF is not pending.
- `d_valid` from memory outside DATA: `d_ready` stays 0. This is a protocol violation and is flagged by a bench assertion.

## Timing
- Reset values:
  - State IDLE, `owner = 0`, `ma_streak = 0`.
  - `mem_bus.a_valid = 0`, `mem_bus.d_ready = 0`.
  - Both `a_ready = 0`, both `d_valid = 0`.
- Arbitration latency:
  - Pending seen in cycle N; owner registered at the end of N.
  - `mem_bus.a_valid` visible in cycle N+1 (the first ADDR cycle).
- A and D paths are combinational pass-through once owned. There are no extra pipeline registers, so there is zero added latency per beat.
- Return to IDLE after D: arbitration happens in the next cycle, giving one bubble cycle between transactions of different owners.
- HOLD → ADDR adds no bubble: owner `a_valid` in HOLD forwards in the same cycle.
- Simultaneous D completion and owner request drop: go to IDLE; request is sampled in the D-handshake cycle.
- Requests asserted in the same cycle: resolved by the priority/streak rule only.
- Reset mid-transaction: immediate return to the reset values; the memory side shares `rst_n`, so no response is drained.

## Structure
- A shared package `tl_arb_pkg` holds:
  - the state enum (`ARB_IDLE`, `ARB_ADDR`, `ARB_DATA`, `ARB_HOLD`);
  - the owner encoding constants (`OWN_NONE`, `OWN_IF`, `OWN_MA`).
- TileLink field widths come from the existing `tilelink` interface.
- One sub-module, `tl_arb_pick`: a combinational priority/streak selector taking both pending bits plus `ma_streak` and producing the grant. Everything else stays in `tl_arbiter`.

## Test plan
- Reset: assert `rst_n = 0` mid-DATA → all outputs return to reset values in the same cycle; after release, `owner = 0`.
- IF-only read:
  - Stimulus: IF `a_valid` with address 0x8000_0000 in cycle 0; memory `a_ready` in cycle 1; `d_valid` with data 0x1234 in cycle 3.
  - Required: `mem_bus.a_valid` high in cycle 1, IF receives 0x1234 in cycle 3, `owner` = 1 then 0.
- Tie: IF and MA request in the same cycle → MA granted first; IF granted in the cycle after MA's D handshake plus one bubble.
- Starvation (`MAX_MA_STREAK = 4`): MA requests continuously with IF pending → the grant sequence is MA, MA, MA, MA, IF, MA…
- Lock: MA holds `ma_request` across two transactions (PTE read, then data read) while IF is pending → both go to MA back-to-back with no IF grant between; IF is granted only after `ma_request` drops.
- Backpressure:
  - Memory `a_ready` held low for 5 cycles → owner `a_ready` stays low and the A fields stay stable.
  - Owner `d_ready` low for 3 cycles → `mem_bus.d_ready` mirrors it and DATA persists.
